// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the bus-facing component.
// Optional idle-timeout interrupt enabled by defining UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo #(
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 16,
  parameter int AW             = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_byte,
  input  logic                  rx_complete,
  input  logic                  rd_strobe,
  input  logic                  flush,
  input  logic                  clr_overrun,
  input  logic [AW:0]           threshold,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [AW:0]           count,
  output logic                  overrun,
  output logic                  irq
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic {
    IDLE,
    ARMED
  } irq_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           cnt;
  logic                  push;
  logic                  pop;
  logic                  ovf;
  logic                  thr_irq;
  irq_state_t            state;
  irq_state_t            state_nxt;

  assign empty   = (cnt == '0);
  assign full    = (cnt == DEPTH_C);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];

  assign pop  = rd_strobe & ~empty;
  assign push = rx_complete & (~full | pop);
  // A dropped byte during flush is not an overflow; flush discards it anyway
  assign ovf  = rx_complete & full & ~pop & ~flush;

  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem[wr_ptr] <= rx_byte;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case (1'b1)
        push && !pop: cnt <= cnt + 1'b1;
        pop && !push: cnt <= cnt - 1'b1;
        default:      cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (ovf) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (threshold != '0 && cnt >= threshold) begin
          state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (threshold == '0 || cnt < threshold) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
    end
  end

  assign thr_irq = (state == ARMED);

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] idle_cnt;
  logic          to_hit;

  always_ff @(posedge clock) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (push || pop || flush || empty) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TO_MAX) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign to_hit = (idle_cnt == TO_MAX);
  assign irq    = thr_irq | to_hit;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign irq            = thr_irq;
`endif

endmodule
